vram_arbiter: RTL and testbench

//  Shares the single-port 16-bit video RAM between the display fetch engine and CPU bus accesses.

---
 rtl/video_pkg.sv | 8 +
 rtl/arb_req_latch.sv | 50 +++++
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared state type, address width and byte-enable helper for the VRAM arbiter
package video_pkg;
    typedef enum logic [1:0] {IDLE, VRD, CRD, CWR} arb_state_e;
    localparam int VRAM_AW = 14;
    function automatic logic [1:0] byte_en(input logic [1:0] wtbt);
        return (wtbt == 2'b00) ? 2'b11 : wtbt;
    endfunction
endpackage

// File: rtl/arb_req_latch.sv
// arb_req_latch: CPU strobe edge detector and holding register for the CPU request
module arb_req_latch
    import video_pkg::*;
#(
    parameter int AW = VRAM_AW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_wtbt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic          rise_o,
    output logic          we_o,
    output logic [1:0]    wtbt_o,
    output logic [AW-1:0] addr_o,
    output logic [15:0]   din_o
);
    logic          old_stb_q;
    logic          we_q;
    logic [1:0]    wtbt_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   din_q;

    assign rise_o = cpu_stb & ~old_stb_q;
    // On the edge cycle the live bus is forwarded so a grant can happen at once
    assign we_o   = rise_o ? cpu_we   : we_q;
    assign wtbt_o = rise_o ? cpu_wtbt : wtbt_q;
    assign addr_o = rise_o ? cpu_addr : addr_q;
    assign din_o  = rise_o ? cpu_din  : din_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_stb_q <= 1'b0;
            we_q      <= 1'b0;
            wtbt_q    <= 2'b00;
            addr_q    <= '0;
            din_q     <= 16'h0000;
        end else begin
            old_stb_q <= cpu_stb;
            if (rise_o) begin
                we_q   <= cpu_we;
                wtbt_q <= cpu_wtbt;
                addr_q <= cpu_addr;
                din_q  <= cpu_din;
            end
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between display fetch (priority, bounded latency)
// and CPU bus accesses, stalling the CPU through cpu_ack.
module vram_arbiter
    import video_pkg::*;
#(
    parameter int AW          = VRAM_AW,
    parameter int RAM_LATENCY = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          vid_ovf,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_wtbt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic [15:0]   cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    input  logic [15:0]   ram_dout
);
    localparam logic [1:0] LAT = 2'(RAM_LATENCY);

    arb_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_vid_q, last_vid_d;
    logic          vid_pend_q, vid_pend_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic          vid_ovf_q, vid_ovf_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic [1:0]    wbe_q, wbe_d;
    logic [15:0]   vid_data_q, vid_data_d;
    logic          vid_valid_q, vid_valid_d;
    logic [15:0]   cpu_dout_q, cpu_dout_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q, ram_din_d;
    logic          ram_we_q, ram_we_d;
    logic [1:0]    ram_be_q, ram_be_d;

    logic          rise, req_we;
    logic [1:0]    req_wtbt;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_din;
    logic          vp, cp, vg, cg, done;

    arb_req_latch #(.AW(AW)) u_req (
        .clk_sys (clk_sys),
        .reset   (reset),
        .cpu_stb (cpu_stb),
        .cpu_we  (cpu_we),
        .cpu_wtbt(cpu_wtbt),
        .cpu_addr(cpu_addr),
        .cpu_din (cpu_din),
        .rise_o  (rise),
        .we_o    (req_we),
        .wtbt_o  (req_wtbt),
        .addr_o  (req_addr),
        .din_o   (req_din)
    );

    // vid_pend covers the whole fetch, so a second request during it is an overflow
    assign vp   = vid_pend_q | vid_req;
    assign cp   = cpu_stb & (cpu_pend_q | rise);
    assign vg   = (state_q == IDLE) && vp && !(last_vid_q && cp);
    assign cg   = (state_q == IDLE) && cp && !vg;
    assign done = ((state_q == VRD) || (state_q == CRD)) && (cnt_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (vg || cg) ? LAT : ((cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q);
        last_vid_d  = vg ? 1'b1 : (cg ? 1'b0 : last_vid_q);
        vid_pend_d  = (vid_req & ~vid_pend_q) | (vid_pend_q & ~((state_q == VRD) && done));
        vid_addr_d  = (vid_req & ~vid_pend_q) ? vid_addr : vid_addr_q;
        vid_ovf_d   = vid_ovf_q | (vid_req & vid_pend_q);
        cpu_pend_d  = cp & ~cg;
        wbe_d       = cg ? byte_en(req_wtbt) : wbe_q;
        ram_addr_d  = vg ? (vid_pend_q ? vid_addr_q : vid_addr) : (cg ? req_addr : ram_addr_q);
        ram_din_d   = (cg && req_we) ? req_din : ram_din_q;
        ram_we_d    = (state_q == CWR);
        ram_be_d    = (state_q == CWR) ? wbe_q : 2'b00;
        vid_valid_d = (state_q == VRD) && done;
        vid_data_d  = vid_valid_d ? ram_dout : vid_data_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_dout_d  = cpu_dout_q;
        if (vg)
            state_d = VRD;
        else if (cg)
            state_d = req_we ? CWR : CRD;
        else if (done || (state_q == CWR))
            state_d = IDLE;
        // A strobe that has already dropped gets no ack, even if its access completes
        if (!cpu_stb) begin
            cpu_ack_d  = 1'b0;
            cpu_dout_d = 16'h0000;
        end else if ((state_q == CRD) && done) begin
            cpu_ack_d  = 1'b1;
            cpu_dout_d = ram_dout;
        end else if (state_q == CWR) begin
            cpu_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_vid_q  <= 1'b0;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            vid_ovf_q   <= 1'b0;
            cpu_pend_q  <= 1'b0;
            wbe_q       <= 2'b00;
            vid_data_q  <= 16'h0000;
            vid_valid_q <= 1'b0;
            cpu_dout_q  <= 16'h0000;
            cpu_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 16'h0000;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_vid_q  <= last_vid_d;
            vid_pend_q  <= vid_pend_d;
            vid_addr_q  <= vid_addr_d;
            vid_ovf_q   <= vid_ovf_d;
            cpu_pend_q  <= cpu_pend_d;
            wbe_q       <= wbe_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
        end
    end

    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign vid_ovf   = vid_ovf_q;
    assign cpu_dout  = cpu_dout_q;
    assign cpu_ack   = cpu_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: cycle-by-cycle vector table plus directed corner-case sequences,
// with a byte-writable VRAM model of one cycle read latency.
module tb_vram_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0;
    logic [13:0] vid_addr = '0;
    logic [15:0] vid_data;
    logic        vid_valid, vid_ovf;
    logic        cpu_stb = 1'b0, cpu_we = 1'b0;
    logic [1:0]  cpu_wtbt = 2'b00;
    logic [13:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [13:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [15:0] ram_dout;
    logic [15:0] mem [0:16383];

    int errors = 0;
    int checks = 0;
    int n_valid, n_ack, seen_bad;

    typedef struct {
        logic        rst, vreq;
        logic [13:0] vaddr;
        logic        stb, we;
        logic [1:0]  wtbt;
        logic [13:0] caddr;
        logic [15:0] din;
        logic [37:0] exp;
    } vec_t;
    vec_t tbl[$];

    vram_arbiter #(.AW(14), .RAM_LATENCY(1)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_ovf(vid_ovf),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_be(ram_be),
        .ram_dout(ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (reset) begin
            mem[14'h0040] <= 16'h3456;
            mem[14'h0123] <= 16'hA5A5;
            mem[14'h0200] <= 16'hBEEF;
            mem[14'h0300] <= 16'hC0DE;
            mem[14'h0400] <= 16'h1111;
            mem[14'h0500] <= 16'h2222;
        end else if (ram_we) begin
            if (ram_be[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            if (ram_be[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        end
        ram_dout <= mem[ram_addr];
    end

    function automatic vec_t v(input logic rst, vreq, input logic [13:0] vaddr,
                               input logic stb, we, input logic [1:0] wtbt,
                               input logic [13:0] caddr, input logic [15:0] din,
                               input logic vv, input logic [15:0] vd, input logic ovf,
                               input logic ack, input logic [15:0] cd,
                               input logic rwe, input logic [1:0] be);
        vec_t r;
        r.rst = rst; r.vreq = vreq; r.vaddr = vaddr; r.stb = stb; r.we = we;
        r.wtbt = wtbt; r.caddr = caddr; r.din = din;
        r.exp = {vv, vd, ovf, ack, cd, rwe, be};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic vreq, input logic [13:0] vaddr, input logic stb, we,
                         input logic [1:0] wtbt, input logic [13:0] caddr, input logic [15:0] din);
        vid_req = vreq; vid_addr = vaddr; cpu_stb = stb; cpu_we = we;
        cpu_wtbt = wtbt; cpu_addr = caddr; cpu_din = din;
    endtask

    initial begin
        // reset
        tbl.push_back(v(1,0,0,      0,0,0,0,      0,      0,16'h0,   0,0,16'h0,   0,0));
        tbl.push_back(v(1,0,0,      0,0,0,0,      0,      0,16'h0,   0,0,16'h0,   0,0));
        // lone video fetch
        tbl.push_back(v(0,1,'h0123, 0,0,0,0,      0,      0,16'h0,   0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'h0,   0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      1,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'hA5A5,0,0,16'h0,   0,0));
        // CPU upper-byte write, ack held until strobe drops
        tbl.push_back(v(0,0,0,      1,1,2,'h0040, 'h12FF, 0,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,1,2,'h0040, 'h12FF, 0,16'hA5A5,0,1,16'h0,   1,2));
        tbl.push_back(v(0,0,0,      1,1,2,'h0040, 'h12FF, 0,16'hA5A5,0,1,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'hA5A5,0,0,16'h0,   0,0));
        // CPU read back of the partially written word
        tbl.push_back(v(0,0,0,      1,0,0,'h0040, 0,      0,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0040, 0,      0,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0040, 0,      0,16'hA5A5,0,1,16'h1256,0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'hA5A5,0,0,16'h0,   0,0));
        // collision, last grant was CPU: video first
        tbl.push_back(v(0,1,'h0200, 1,0,0,'h0300, 0,      0,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0300, 0,      0,16'hA5A5,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0300, 0,      1,16'hBEEF,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0300, 0,      0,16'hBEEF,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0300, 0,      0,16'hBEEF,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0300, 0,      0,16'hBEEF,0,1,16'hC0DE,0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'hBEEF,0,0,16'h0,   0,0));
        // lone video to make the last grant video
        tbl.push_back(v(0,1,'h0400, 0,0,0,0,      0,      0,16'hBEEF,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'hBEEF,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      1,16'h1111,0,0,16'h0,   0,0));
        // collision, last grant was video: CPU first, video waits worst case
        tbl.push_back(v(0,1,'h0500, 1,0,0,'h0200, 0,      0,16'h1111,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0200, 0,      0,16'h1111,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0200, 0,      0,16'h1111,0,1,16'hBEEF,0,0));
        tbl.push_back(v(0,0,0,      1,0,0,'h0200, 0,      0,16'h1111,0,1,16'hBEEF,0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'h1111,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      1,16'h2222,0,0,16'h0,   0,0));
        tbl.push_back(v(0,0,0,      0,0,0,0,      0,      0,16'h2222,0,0,16'h0,   0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            drive(tbl[i].vreq, tbl[i].vaddr, tbl[i].stb, tbl[i].we, tbl[i].wtbt, tbl[i].caddr, tbl[i].din);
            tick();
            chk($sformatf("vec%0d", i),
                64'({vid_valid, vid_data, vid_ovf, cpu_ack, cpu_dout, ram_we, ram_be}), 64'(tbl[i].exp));
        end

        // back-to-back video requests: overflow, single fetch of the first address
        drive(1, 'h0123, 0, 0, 0, 0, 0);
        tick();
        chk("ovf_first_addr", 64'(ram_addr), 64'h0123);
        drive(1, 'h0400, 0, 0, 0, 0, 0);
        tick();
        chk("ovf_set", 64'(vid_ovf), 64'h1);
        drive(0, 0, 0, 0, 0, 0, 0);
        n_valid = 0; seen_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vid_valid) n_valid++;
            if (ram_addr != 14'h0123) seen_bad++;
        end
        chk("ovf_one_fetch", 64'(n_valid), 64'h1);
        chk("ovf_no_refetch", 64'(seen_bad), 64'h0);
        chk("ovf_data", 64'({vid_data, vid_ovf}), 64'h1_A5A5 << 0 | 64'h0 ? 64'({16'hA5A5, 1'b1}) : 64'h0);

        // CPU read abandoned while video is busy
        n_valid = 0; n_ack = 0; seen_bad = 0;
        drive(1, 'h0200, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 'h0300, 0);
        tick();
        if (cpu_ack) n_ack++;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (vid_valid) n_valid++;
            if (cpu_ack) n_ack++;
            if (ram_addr == 14'h0300) seen_bad++;
        end
        chk("abandon_no_ack", 64'(n_ack), 64'h0);
        chk("abandon_no_access", 64'(seen_bad), 64'h0);
        chk("abandon_video", 64'({n_valid[3:0], vid_data}), 64'h1BEEF);

        // full-word write uses both byte enables
        drive(0, 0, 1, 1, 0, 'h0600, 'h7777);
        tick();
        tick();
        chk("full_write", 64'({ram_we, ram_be, ram_din, ram_addr}), 64'({1'b1, 2'b11, 16'h7777, 14'h0600}));
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // reset during CWR before the write-enable cycle
        drive(0, 0, 1, 1, 1, 'h0040, 'h9999);
        tick();
        reset = 1'b1;
        tick();
        chk("reset_outputs",
            64'({vid_data, vid_valid, vid_ovf, cpu_dout, cpu_ack, ram_we, ram_be, ram_addr[12:0]}), 64'h0);
        chk("reset_ram_din", 64'({ram_addr[13], ram_din}), 64'h0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        seen_bad = 0; n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_we) seen_bad++;
            if (cpu_ack) n_ack++;
        end
        chk("reset_no_we", 64'(seen_bad), 64'h0);
        chk("reset_no_ack", 64'(n_ack), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
